sysbus_mem_responder: RTL and testbench

Memory-side responder for the Sysbus line-transfer protocol: it accepts line read/write requests from a cache's memory port (`m_bus_*`) and services them from an internal line-organised backing store. Each transfer moves one 512-bit line as eight 64-bit beats. It sits in the testbench and top-level wrappers directly beneath the cache, in place of DRAM, and gives the cache a deterministic, parameterisable-latency memory to run against.

---
 rtl/sysbus_mem_responder.sv | 149 ++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// Sysbus line-transfer memory responder: serves 8-beat line reads/writes from an internal line store.
// Read latency: ack one cycle after request, first beat READ_LATENCY cycles later; writes commit one cycle after beat 7.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_LINES      = 64,
  parameter int OFFSET         = 6,
  parameter int BEATS          = 8,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int   IDX_W        = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int   BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int   LAT_W        = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic SYSBUS_WRITE = 1'b1;

  typedef logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] line_t;
  typedef enum logic [2:0] {IDLE, ACK, WDATA, COMMIT, WAIT, RDATA} state_t;

  state_t                   state, state_nxt;
  logic [BEAT_W-1:0]        beat, beat_nxt;
  logic [LAT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         idx;
  logic [BUS_TAG_WIDTH-1:0] tag;
  line_t                    line_buf;
  line_t                    store [NUM_LINES];

  logic cap_req, wr_beat, load_line, commit;
  logic last_beat;

  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat;
    cnt_nxt     = cnt;
    cap_req     = 1'b0;
    wr_beat     = 1'b0;
    load_line   = 1'b0;
    commit      = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    case (state)
      IDLE: begin
        if (bus_reqcyc) begin
          cap_req   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        bus_reqack = 1'b1;
        beat_nxt   = '0;
        if (tag[BUS_TAG_WIDTH-1] == SYSBUS_WRITE) begin
          state_nxt = WDATA;
        end else if (READ_LATENCY == 0) begin
          load_line = 1'b1;
          state_nxt = RDATA;
        end else begin
          cnt_nxt   = LAT_W'(READ_LATENCY);
          state_nxt = WAIT;
        end
      end
      WDATA: begin
        bus_reqack = bus_reqcyc;
        if (bus_reqcyc) begin
          wr_beat  = 1'b1;
          beat_nxt = beat + BEAT_W'(1);
          if (last_beat) begin
            beat_nxt  = '0;
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      WAIT: begin
        // The store is sampled on the last wait cycle so the buffer is ready for the first beat.
        cnt_nxt = cnt - LAT_W'(1);
        if (cnt_nxt == '0) begin
          load_line = 1'b1;
          beat_nxt  = '0;
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        bus_respcyc = 1'b1;
        bus_resp    = line_buf[beat];
        bus_resptag = tag;
        if (bus_respack) begin
          beat_nxt = beat + BEAT_W'(1);
          if (last_beat) begin
            beat_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat     <= '0;
      cnt      <= '0;
      idx      <= '0;
      tag      <= '0;
      line_buf <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      cnt   <= cnt_nxt;
      if (cap_req) begin
        idx <= bus_req[OFFSET+IDX_W-1:OFFSET];
        tag <= bus_reqtag;
      end
      if (wr_beat)
        line_buf[beat] <= bus_req;
      else if (load_line)
        line_buf <= store[idx];
    end
  end

  // Only COMMIT writes the store, so a write cut short by reset never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++)
        store[i] <= '0;
    end else if (commit) begin
      store[idx] <= line_buf;
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: directed protocol scenarios plus randomized traffic against a line-array model.
module tb_sysbus_mem_responder;
  localparam int DW  = 64;
  localparam int TW  = 13;
  localparam int NL  = 64;
  localparam int OFS = 6;
  localparam int NB  = 8;
  localparam int RL  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bus_reqcyc;
  logic          bus_reqack;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_respcyc;
  logic          bus_respack;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [NL][NB];
  logic [DW-1:0] wbuf [NB];

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .NUM_LINES(NL),
    .OFFSET(OFS), .BEATS(NB), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  function automatic int line_of(input logic [DW-1:0] addr);
    return int'((addr / 64'(2 ** OFS)) % 64'(NL));
  endfunction

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < NL; l++)
      for (int b = 0; b < NB; b++)
        model[l][b] = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bus_reqcyc = 1'b0; bus_respack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    #1;
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
  endtask

  // Issues a write of wbuf; gap_pct sets the chance of an idle cycle before each beat.
  // abort_after >= 0 asserts reset once that many beats have been accepted.
  task automatic do_write(input logic [DW-1:0] addr, input int gap_pct, input int abort_after);
    int b;
    int guard;
    @(negedge clk);
    bus_reqcyc = 1'b1; bus_req = addr;
    bus_reqtag = {1'b1, 12'($urandom)};
    #1 check("wr_req_noack", 64'(bus_reqack), 64'd0);
    @(negedge clk);
    bus_reqcyc = 1'b0; bus_req = {$urandom, $urandom};
    #1 check("wr_ack", 64'(bus_reqack), 64'd1);
    b = 0;
    guard = 0;
    while (b < NB && guard < 200) begin
      if (abort_after >= 0 && b == abort_after) begin
        apply_reset();
        return;
      end
      @(negedge clk);
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        bus_reqcyc = 1'b0; bus_req = {$urandom, $urandom};
      end else begin
        bus_reqcyc = 1'b1; bus_req = wbuf[b];
      end
      #1 check("wr_beat_ack", 64'(bus_reqack), 64'(bus_reqcyc));
      if (bus_reqcyc) b++;
    end
    if (b < NB) check("wr_timeout", 64'(b), 64'(NB));
    @(negedge clk);
    bus_reqcyc = 1'b1; bus_req = {$urandom, $urandom};
    #1 check("commit_quiet", 64'({bus_reqack, bus_respcyc}), 64'd0);
    @(negedge clk);
    bus_reqcyc = 1'b0;
    for (int k = 0; k < NB; k++) model[line_of(addr)][k] = wbuf[k];
  endtask

  // Reads a line; stall_len cycles without ack are inserted on beat stall_beat.
  task automatic do_read(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                         input int stall_beat, input int stall_len);
    int b, left, j;
    bit seen;
    logic [DW-1:0] exp;
    @(negedge clk);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b0;
    #1 check("rd_req_idle", 64'({bus_reqack, bus_respcyc}), 64'd0);
    @(negedge clk);
    bus_reqcyc = 1'b0; bus_req = {$urandom, $urandom};
    #1 check("rd_ack", 64'(bus_reqack), 64'd1);
    b = 0; left = stall_len; seen = 1'b0; j = 0;
    while (b < NB && j < 200) begin
      @(negedge clk);
      bus_respack = 1'b0;
      bus_reqcyc = $urandom_range(1);
      #1;
      if (!bus_respcyc) begin
        if (seen) check("rd_respcyc_drop", 64'd0, 64'd1);
        check("rd_reqack_quiet", 64'(bus_reqack), 64'd0);
      end else begin
        if (!seen) check("rd_latency", 64'(j), 64'(RL));
        seen = 1'b1;
        exp = model[line_of(addr)][b];
        check("rd_data", bus_resp, exp);
        check("rd_tag", 64'(bus_resptag), 64'(tag));
        if (b == stall_beat && left > 0) begin
          left--;
        end else begin
          bus_respack = 1'b1;
          b++;
        end
      end
      j++;
    end
    if (b < NB) check("rd_timeout", 64'(b), 64'(NB));
    @(negedge clk);
    bus_respack = 1'b0; bus_reqcyc = 1'b0;
    #1 check("rd_back_idle", 64'(bus_respcyc), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] a;
    reset = 1'b1; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    apply_reset();

    do_read(64'h0, 13'h0001, -1, 0);

    for (int k = 0; k < NB; k++) wbuf[k] = 64'h1000 + 64'(k);
    do_write(64'h1040, 0, -1);
    do_read(64'h1040, 13'h0123, -1, 0);
    do_read(64'h1040 + 64'h3F, 13'h0456, -1, 0);

    do_read(64'h1040, 13'h0ABC, 2, 3);

    for (int k = 0; k < NB; k++) wbuf[k] = {$urandom, $urandom};
    do_write(64'h0200, 50, -1);
    do_read(64'h0200, 13'h0011, -1, 0);

    for (int k = 0; k < NB; k++) wbuf[k] = {$urandom, $urandom};
    do_write(64'h40, 0, -1);
    do_read(64'h40 + 64'(NL * 64), 13'h0022, -1, 0);

    for (int k = 0; k < NB; k++) wbuf[k] = 64'hDEAD_0000 + 64'(k);
    do_write(64'h80, 0, 5);
    do_read(64'h80, 13'h0033, -1, 0);

    for (int it = 0; it < 40; it++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(1) == 1) begin
        for (int k = 0; k < NB; k++) wbuf[k] = {$urandom, $urandom};
        do_write(a, int'($urandom_range(60)), -1);
      end else begin
        do_read(a, {1'b0, 12'($urandom)}, int'($urandom_range(NB - 1)), int'($urandom_range(3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
